// File: rtl/bus_arbiter.sv
// bus_arbiter: owns the external memory bus, running 4-T-state cycles for the CPU port and a built-in page-copy DMA.
module bus_arbiter #(
  parameter int          DMA_LEN = 160,
  parameter logic [15:0] DMA_DST = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_done,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_start,
  input  logic [7:0]  dma_src_hi,
  output logic        dma_busy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_we,
  output logic        mem_data_oe
);
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3} state_t;
  state_t      state, state_nx;
  logic        cur_dma, cur_we, dphase, arb, last, dma_go;
  logic [7:0]  src_hi;
  logic [8:0]  idx;
  assign arb     = (state == IDLE) || (state == T3);
  // idx advances when a write is launched, so the final write's T3 sees idx == DMA_LEN
  assign last    = (state == T3) && cur_dma && cur_we && (idx == 9'(DMA_LEN));
  assign dma_go  = arb && dma_busy && !last && !rst;
  assign cpu_gnt = cpu_req && arb && !dma_busy && !rst;
  assign mem_cs      = state != IDLE;
  assign mem_oe      = !cur_we && (state == T1 || state == T2 || state == T3);
  assign mem_we      = cur_we && (state == T1 || state == T2);
  assign mem_data_oe = cur_we && mem_cs;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = (arb && (dma_go || cpu_gnt)) ? T0 :
               (state == T0) ? T1 :
               (state == T1) ? T2 :
               (state == T2) ? T3 : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_dma   <= 1'b0;
      cur_we    <= 1'b0;
      dphase    <= 1'b0;
      src_hi    <= '0;
      idx       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_done  <= 1'b0;
      cpu_rdata <= '0;
      dma_busy  <= 1'b0;
    end else begin
      cpu_done <= (state == T3) && !cur_dma;
      if ((state == T3) && !cur_dma && !cur_we) cpu_rdata <= mem_rdata;
      if (dma_start && !dma_busy) begin
        src_hi   <= dma_src_hi;
        idx      <= '0;
        dphase   <= 1'b0;
        dma_busy <= 1'b1;
      end
      if (last) dma_busy <= 1'b0;
      if (dma_go) begin
        cur_dma  <= 1'b1;
        cur_we   <= dphase;
        dphase   <= !dphase;
        mem_addr <= dphase ? DMA_DST + 16'(idx) : {src_hi, idx[7:0]};
        if (dphase) begin
          mem_wdata <= mem_rdata;
          idx       <= idx + 9'd1;
        end
      end else if (cpu_gnt) begin
        cur_dma   <= 1'b0;
        cur_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of CPU cycles, reset abort, DMA copy and DMA/CPU arbitration.
module tb_bus_arbiter;
  logic        clk = 0, rst = 1;
  logic        cpu_req = 0, cpu_we = 0;
  logic [15:0] cpu_addr = 0;
  logic [7:0]  cpu_wdata = 0, dma_src_hi = 0, mem_rdata;
  logic        dma_start = 0;
  logic        cpu_gnt, cpu_done, dma_busy, mem_cs, mem_oe, mem_we, mem_data_oe;
  logic [7:0]  cpu_rdata, mem_wdata;
  logic [15:0] mem_addr;
  int vec = 0, miss = 0;
  bus_arbiter dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dma_start(dma_start), .dma_src_hi(dma_src_hi), .dma_busy(dma_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we), .mem_data_oe(mem_data_oe)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] pat(input logic [15:0] a);
    return (a == 16'h1234) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h5A);
  endfunction
  assign mem_rdata = pat(mem_addr);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic strobes(input string tag, input logic cs, oe, we, doe);
    chk({tag, ".cs"}, 32'(mem_cs), 32'(cs));
    chk({tag, ".oe"}, 32'(mem_oe), 32'(oe));
    chk({tag, ".we"}, 32'(mem_we), 32'(we));
    chk({tag, ".doe"}, 32'(mem_data_oe), 32'(doe));
  endtask
  initial begin
    int n, cs_n, rn, wn, gv, dn;
    logic pw, po;
    cpu_req = 1;
    tick(); tick();
    chk("rst.gnt", 32'(cpu_gnt), 0);
    cpu_req = 0; rst = 0; #1;
    strobes("rst", 0, 0, 0, 0);
    chk("rst.addr", 32'(mem_addr), 0);
    chk("rst.wdata", 32'(mem_wdata), 0);
    chk("rst.done", 32'(cpu_done), 0);
    chk("rst.rdata", 32'(cpu_rdata), 0);
    chk("rst.busy", 32'(dma_busy), 0);
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234; #1;
    chk("rd.gnt", 32'(cpu_gnt), 1);
    tick();
    cpu_req = 0; cpu_addr = 16'hDEAD; #1;
    strobes("rd.t0", 1, 0, 0, 0);
    chk("rd.addr", 32'(mem_addr), 32'h1234);
    tick(); strobes("rd.t1", 1, 1, 0, 0);
    tick(); strobes("rd.t2", 1, 1, 0, 0);
    tick(); strobes("rd.t3", 1, 1, 0, 0);
    chk("rd.t3.done", 32'(cpu_done), 0);
    tick();
    chk("rd.done", 32'(cpu_done), 1);
    chk("rd.rdata", 32'(cpu_rdata), 32'hA5);
    strobes("rd.idle", 0, 0, 0, 0);
    chk("rd.hold.addr", 32'(mem_addr), 32'h1234);
    tick();
    chk("rd.done.clr", 32'(cpu_done), 0);
    chk("rd.rdata.hold", 32'(cpu_rdata), 32'hA5);
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'hC000; cpu_wdata = 8'h3C; #1;
    chk("wr.gnt", 32'(cpu_gnt), 1);
    tick();
    cpu_req = 0; cpu_wdata = 8'hFF; #1;
    strobes("wr.t0", 1, 0, 0, 1);
    chk("wr.addr", 32'(mem_addr), 32'hC000);
    chk("wr.wdata", 32'(mem_wdata), 32'h3C);
    tick(); strobes("wr.t1", 1, 0, 1, 1);
    tick(); strobes("wr.t2", 1, 0, 1, 1);
    tick(); strobes("wr.t3", 1, 0, 0, 1);
    tick();
    chk("wr.done", 32'(cpu_done), 1);
    chk("wr.rdata", 32'(cpu_rdata), 32'hA5);
    strobes("wr.idle", 0, 0, 0, 0);
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; #1;
    chk("b2b.gnt0", 32'(cpu_gnt), 1);
    tick(); tick(); tick();
    chk("b2b.t2.gnt", 32'(cpu_gnt), 0);
    tick();
    chk("b2b.t3.gnt", 32'(cpu_gnt), 1);
    tick();
    cpu_addr = 16'h0020; #1;
    chk("b2b.done1", 32'(cpu_done), 1);
    chk("b2b.rdata1", 32'(cpu_rdata), 32'(pat(16'h0010)));
    strobes("b2b.t0b", 1, 0, 0, 0);
    chk("b2b.addr2", 32'(mem_addr), 32'h0010);
    tick(); tick(); tick();
    chk("b2b.t3b.gnt", 32'(cpu_gnt), 1);
    cpu_req = 0; #1;
    chk("b2b.t3b.drop", 32'(cpu_done), 0);
    tick();
    chk("b2b.done2", 32'(cpu_done), 1);
    chk("b2b.rdata2", 32'(cpu_rdata), 32'(pat(16'h0010)));
    strobes("b2b.idle", 0, 0, 0, 0);
    cpu_req = 1; cpu_addr = 16'h0030; #1;
    chk("ab.gnt", 32'(cpu_gnt), 1);
    tick();
    cpu_req = 0;
    tick(); tick();
    strobes("ab.t2", 1, 1, 0, 0);
    rst = 1;
    tick();
    rst = 0; #1;
    strobes("ab.rst", 0, 0, 0, 0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (cpu_done) dn++;
      tick();
    end
    chk("ab.nodone", 32'(dn), 0);
    chk("ab.rdata", 32'(cpu_rdata), 0);
    dma_start = 1; dma_src_hi = 8'hC1;
    tick();
    dma_start = 0; #1;
    chk("dma.busy", 32'(dma_busy), 1);
    n = 1; cs_n = 0; rn = 0; wn = 0; dn = 0; pw = 0; po = 0;
    while (dma_busy && n < 3000) begin
      tick();
      dma_start = (n == 100);
      dma_src_hi = (n == 100) ? 8'h55 : 8'hC1;
      if (dma_busy) n++;
      if (mem_cs) cs_n++;
      if (mem_oe && !po) rn++;
      if (cpu_done) dn++;
      if (mem_we && !pw) begin
        chk("dma.waddr", 32'(mem_addr), 32'(16'hFE00 + 16'(wn)));
        chk("dma.wdata", 32'(mem_wdata), 32'(pat(16'hC100 + 16'(wn))));
        wn++;
      end
      pw = mem_we; po = mem_oe;
    end
    dma_start = 0;
    chk("dma.busyclks", 32'(n), 1281);
    chk("dma.csclks", 32'(cs_n), 1280);
    chk("dma.reads", 32'(rn), 160);
    chk("dma.writes", 32'(wn), 160);
    chk("dma.nodone", 32'(dn), 0);
    strobes("dma.idle", 0, 0, 0, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040; #1;
    chk("mix.gnt", 32'(cpu_gnt), 1);
    tick();
    cpu_addr = 16'h0050;
    tick();
    dma_start = 1; dma_src_hi = 8'h22;
    tick();
    dma_start = 0; #1;
    chk("mix.busy", 32'(dma_busy), 1);
    chk("mix.t2.gnt", 32'(cpu_gnt), 0);
    tick();
    chk("mix.t3.gnt", 32'(cpu_gnt), 0);
    tick();
    chk("mix.done", 32'(cpu_done), 1);
    chk("mix.rdata", 32'(cpu_rdata), 32'(pat(16'h0040)));
    strobes("mix.dma.t0", 1, 0, 0, 0);
    chk("mix.dma.addr", 32'(mem_addr), 32'h2200);
    gv = 0; n = 0;
    while (dma_busy && n < 3000) begin
      if (cpu_gnt) gv++;
      tick();
      n++;
    end
    chk("mix.stall", 32'(gv), 0);
    chk("mix.end", 32'(dma_busy), 0);
    chk("mix.gnt.after", 32'(cpu_gnt), 1);
    tick();
    cpu_req = 0; #1;
    chk("mix.cpu.addr", 32'(mem_addr), 32'h0050);
    strobes("mix.cpu.t0", 1, 0, 0, 0);
    tick(); tick(); tick(); tick();
    chk("mix.cpu.done", 32'(cpu_done), 1);
    chk("mix.cpu.rdata", 32'(cpu_rdata), 32'(pat(16'h0050)));
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Owns the external memory bus and runs fixed 4-T-state machine cycles (T0..T3) on behalf of two requesters: the CPU control unit and an OAM-style DMA engine built into this block.
- The CPU side is a valid/grant request port plus a completion pulse.
- The DMA side copies a 256-byte-aligned source page into a fixed destination window, one read cycle and one write cycle per byte.
- Drives mem_cs/mem_oe/mem_we, the address, and the data-drive enable for the tri-state external bus.

Parameters:
DMA_LEN, 160, bytes transferred per DMA run (1..256)
DMA_DST, 16'hFE00, destination base address of DMA writes

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cpu_req  input  1  CPU access request (level, held until granted)
cpu_we  input  1  1 = write, 0 = read; sampled on grant
cpu_addr  input  16  access address; sampled on grant
cpu_wdata  input  8  write data; sampled on grant
cpu_gnt  output  1  request accepted this clock (combinational)
cpu_done  output  1  one-clock pulse, CPU cycle complete
cpu_rdata  output  8  read data, valid with cpu_done, held until next CPU read completes
dma_start  input  1  one-clock start pulse
dma_src_hi  input  8  source page; sampled with dma_start
dma_busy  output  1  DMA run in progress
mem_addr  output  16  external address
mem_wdata  output  8  external write data
mem_rdata  input  8  external read data
mem_cs  output  1  chip select
mem_oe  output  1  read output enable
mem_we  output  1  write strobe
mem_data_oe  output  1  enable for driving mem_wdata onto the data bus

Behaviour:
- Reset: on a clk edge with rst=1, state=IDLE and the DMA index is cleared.
  - All outputs go to 0: mem_cs, mem_oe, mem_we, mem_data_oe, mem_addr, mem_wdata, cpu_done, cpu_rdata, dma_busy; cpu_gnt=0 while rst=1.
  - Reset mid-cycle or mid-DMA aborts immediately. No cpu_done is emitted and the DMA does not resume.
- State machine: IDLE -> T0 -> T1 -> T2 -> T3 -> (T0 if a new cycle is granted, else IDLE).
  - No idle gap between back-to-back cycles.
- Arbitration points: only in IDLE or T3. A cycle in progress is never preempted.
  - Priority at each point: pending DMA step beats cpu_req.
  - cpu_gnt = cpu_req & (state==IDLE | state==T3) & ~dma_step_pending & ~rst.
  - On grant, cpu_we/cpu_addr/cpu_wdata are latched. The CPU may change them the next clock.
- Strobes per cycle:
  - mem_cs=1 in T0..T3.
  - mem_addr and mem_wdata are stable T0..T3 and hold their last value in IDLE.
  - Read: mem_oe=1 in T1..T3. mem_rdata is sampled on the edge leaving T3.
  - Write: mem_data_oe=1 in T0..T3; mem_we=1 in T1..T2 only.
- CPU latency: grant at clock k (in IDLE) gives T0 at k+1 and T3 at k+4. cpu_done=1 for exactly clock k+5, with cpu_rdata updated for reads. cpu_rdata is unchanged for writes.
  - Grant issued in T3 behaves the same, with T0 one clock later.
  - cpu_done may coincide with the T0 of the following cycle.
- DMA:
  - dma_start while dma_busy=0 latches dma_src_hi, clears idx, and sets dma_busy from the next clock.
  - dma_start while dma_busy=1 is ignored.
  - Per idx, a read cycle at {src_hi, idx[7:0]} is followed by a write cycle at DMA_DST + idx using the byte latched at the end of the read's T3.
  - idx increments after each write.
  - After the write cycle for idx = DMA_LEN-1, dma_busy clears on the edge leaving that T3.
  - Total clocks from the first DMA T0 to the last T3 inclusive = 8*DMA_LEN.
  - If dma_start arrives during a CPU cycle, that cycle completes normally and the DMA takes the next arbitration point.
  - The CPU is stalled, with cpu_gnt=0, for the whole DMA run.
  - Source addresses are issued as-is with no remapping. idx never wraps because DMA_LEN<=256.
- Simultaneous dma_start and cpu_req in IDLE: the CPU is granted that clock, because the DMA step is not yet pending. The DMA follows at that cycle's T3.

Test Plan:
- Reset then idle: all outputs 0, state IDLE. Assert rst during T2 of a read -> next clock mem_cs=mem_oe=0, no cpu_done ever follows.
- CPU read of 0x1234 with mem_rdata=0xA5 from IDLE: grant at k -> mem_cs k+1..k+4, mem_oe k+2..k+4, cpu_done=1 only at k+5, cpu_rdata=0xA5 held until the next read.
- CPU write 0xC000<-0x3C -> mem_data_oe T0..T3, mem_we high exactly T1..T2 (2 clocks), mem_wdata=0x3C, cpu_done after T3, cpu_rdata unchanged.
- Back-to-back reads, req held high: second grant in T3 -> T0 immediately follows T3, two done pulses 4 clocks apart.
- DMA dma_src_hi=0xC1, DMA_LEN=160, memory model pattern -> 320 cycles. Writes cover FE00..FE9F with data from C100..C19F. dma_busy high for exactly 1280 clocks of cycles plus the start latency. Second dma_start mid-run is ignored.
- dma_start during a CPU read's T1 plus a pending cpu_req -> CPU read completes, DMA owns the bus next, cpu_gnt stays 0 until dma_busy falls, then the CPU is granted at the first arbitration point.
